fetch_issue_ctrl: RTL and testbench
===================================

Name: fetch_issue_ctrl

Overview:
- Sequencer in front of topMod: fetches 16-bit instruction words from instruction memory and loads the stage registers (StageRegInstr_out, StageRegAddrMode_out, StageRegData_out, StageRegPCtr_out).
- Waits for StageComplete, then advances the PC from NextPctr.
- Also handles interrupt entry/return via InteruptAdrReg, HALT, and an execute-stage watchdog.

Parameters:
- RESET_VECTOR, 8'h00, PC loaded on reset.
- HALT_OPCODE, 5'h1F, opcode that stops fetching.
- RETI_OPCODE, 5'h1E, opcode that returns from interrupt.
- WDT_CYCLES, 64, maximum EXEC cycles before timeout; range 2..255.

Ports:
- clk  in  1  Clock, rising edge.
- reset  in  1  Asynchronous, active-low reset.
- imem_req  out  1  Fetch request; held until imem_ack.
- imem_addr  out  8  Fetch address; stable while imem_req is high.
- imem_ack  in  1  Memory accepted request; imem_rdata valid this cycle.
- imem_rdata  in  16  Instruction word: [15:11] opcode, [10:8] addr mode, [7:0] data.
- StageRegInstr_out  out  5  Opcode to datapath.
- StageRegAddrMode_out  out  3  Address mode to datapath.
- StageRegData_out  out  8  Immediate/address to datapath.
- StageRegPCtr_out  out  8  PC of the issued instruction.
- stage_valid  out  1  High while an instruction is executing (EXEC).
- StageComplete  in  1  Datapath finished current instruction; single-cycle pulse.
- NextPctr  in  8  Datapath-computed next PC; valid with StageComplete.
- irq  in  1  Level interrupt request.
- irq_en  in  1  Global interrupt enable.
- InteruptAdrReg  in  8  Interrupt vector.
- irq_ack  out  1  One-cycle pulse on interrupt entry.
- in_isr  out  1  Currently inside the interrupt service routine.
- halted  out  1  In HALT.
- wdt_err  out  1  Sticky watchdog timeout flag.
- retired  out  16  Count of completed instructions; wraps.

Behaviour:
- Reset values (reset low, asynchronous): state = FETCH, pc = RESET_VECTOR, epc = 0, all stage outputs = 0, imem_req = 0, stage_valid = 0, irq_ack = 0, in_isr = 0, halted = 0, wdt_err = 0, retired = 0.
- Reset asserted mid-fetch or mid-exec aborts immediately; there is no memory-side cleanup.
- FETCH: imem_req = 1, imem_addr = pc.
  - On imem_ack, register imem_rdata fields into the stage outputs and pc into StageRegPCtr_out; go to EXEC.
  - Stage outputs change only on this edge.
  - imem_req drops in the cycle after ack.
- EXEC: stage_valid = 1; the watchdog counter increments each cycle. On StageComplete:
  - retired += 1.
  - If opcode == HALT_OPCODE: pc = NextPctr; go to HALT.
  - Else if opcode == RETI_OPCODE and in_isr: pc = epc, in_isr = 0; go to FETCH.
  - Else if irq && irq_en && !in_isr: epc = NextPctr; go to IRQ.
  - Else: pc = NextPctr; go to FETCH.
  - RETI executed with in_isr = 0 is treated as an ordinary instruction.
- Watchdog:
  - If the counter reaches WDT_CYCLES without StageComplete: wdt_err = 1, go to HALT. pc and retired are unchanged.
  - The counter clears on entry to EXEC.
  - StageComplete arriving in the same cycle the count reaches WDT_CYCLES counts as completion (no error).
- IRQ (one cycle): irq_ack = 1, pc = InteruptAdrReg, in_isr = 1; go to FETCH. Interrupts do not nest.
- HALT: halted = 1, imem_req = 0.
  - If irq && irq_en && !wdt_err: epc = pc; go to IRQ, and halted drops.
  - Otherwise stay in HALT until reset. A watchdog halt is exited only by reset.
- Interrupts are sampled only at instruction boundaries (StageComplete) or in HALT, never mid-fetch.
- PC arithmetic is 8-bit; the datapath supplies the wrap (8'hFF -> 8'h00 passes through unchanged).
- retired wraps 16'hFFFF -> 0.

Decomposition:
- Shared package fic_pkg holds:
  - state enum: FETCH, EXEC, IRQ, HALT;
  - instruction field offsets: OPC_MSB = 15, OPC_LSB = 11, MODE_MSB = 10, MODE_LSB = 8, DATA_MSB = 7;
  - default HALT/RETI opcodes.
- One natural sub-module: fic_watchdog (counter, clear, limit compare, sticky error).

Test Plan:
- Reset then fetch: imem_ack with imem_rdata = 16'h0A55 at addr 0 -> StageRegInstr_out = 5'h01, mode = 3'h2, data = 8'h55, StageRegPCtr_out = 0, stage_valid = 1 on the next cycle.
- Sequential run: three instructions, StageComplete with NextPctr = 1, 2, 3 -> imem_addr sequence 0, 1, 2, 3; retired = 3.
- Interrupt: irq = 1, irq_en = 1, InteruptAdrReg = 8'h80, StageComplete with NextPctr = 8'h05 -> irq_ack pulse, next fetch at 8'h80, in_isr = 1. A RETI then resumes the fetch at 8'h05 with in_isr = 0.
- HALT: issue opcode 5'h1F -> halted = 1, imem_req stays 0 for 20 cycles. Raising irq with irq_en = 1 -> fetch at vector; epc = NextPctr of the HALT instruction.
- Watchdog: WDT_CYCLES = 8, no StageComplete -> wdt_err = 1 after 8 EXEC cycles, halted = 1. irq is ignored; only reset clears the error.
- Async reset mid-EXEC: drop reset between clock edges -> all outputs return to their reset values immediately. After release, the next fetch is at RESET_VECTOR.

Source files
------------

// File: rtl/fic_pkg.sv
// Shared types and constants for the fetch/issue sequencer in front of topMod.
package fic_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        IRQ   = 2'd2,
        HALT  = 2'd3
    } ficState_t;

    // Instruction word layout: [15:11] opcode, [10:8] address mode, [7:0] data
    localparam int OPC_MSB  = 15;
    localparam int OPC_LSB  = 11;
    localparam int MODE_MSB = 10;
    localparam int MODE_LSB = 8;
    localparam int DATA_MSB = 7;

    localparam logic [4:0] DEF_HALT_OPCODE = 5'h1F;
    localparam logic [4:0] DEF_RETI_OPCODE = 5'h1E;

    function automatic logic [4:0] opcodeOf(input logic [15:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [2:0] modeOf(input logic [15:0] word);
        return word[MODE_MSB:MODE_LSB];
    endfunction

    function automatic logic [7:0] dataOf(input logic [15:0] word);
        return word[DATA_MSB:0];
    endfunction

endpackage

// File: rtl/fic_watchdog.sv
// Execute-stage watchdog: counts EXEC cycles and latches a sticky error when the
// limit is reached without the datapath completing the instruction.
module fic_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic complete,
    output logic expire,
    output logic wdtErr
);

    localparam logic [7:0] TERMINAL = 8'(LIMIT - 1);

    logic [7:0] count;

    // A completion landing on the terminal cycle wins over the timeout.
    assign expire = run && !complete && (count == TERMINAL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= 8'd0;
            wdtErr <= 1'b0;
        end else begin
            if (clear) begin
                count <= 8'd0;
            end else if (run && (count != TERMINAL)) begin
                count <= count + 8'd1;
            end
            if (expire) begin
                wdtErr <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_issue_ctrl.sv
// Fetch/issue sequencer: fetches instruction words, loads the stage registers,
// and handles completion, interrupt entry/return, HALT and the execute watchdog.
//
// state | meaning
// FETCH | imem_req high at pc, waiting for imem_ack
// EXEC  | stage registers valid, waiting for StageComplete (watchdog running)
// IRQ   | single cycle: irq_ack, pc <- vector, enter ISR
// HALT  | fetching stopped; leaves only via interrupt (if no watchdog error) or reset
module fetch_issue_ctrl
    import fic_pkg::*;
#(
    parameter logic [7:0] RESET_VECTOR = 8'h00,
    parameter logic [4:0] HALT_OPCODE  = DEF_HALT_OPCODE,
    parameter logic [4:0] RETI_OPCODE  = DEF_RETI_OPCODE,
    parameter int         WDT_CYCLES   = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [4:0]  StageRegInstr_out,
    output logic [2:0]  StageRegAddrMode_out,
    output logic [7:0]  StageRegData_out,
    output logic [7:0]  StageRegPCtr_out,
    output logic        stage_valid,
    input  logic        StageComplete,
    input  logic [7:0]  NextPctr,
    input  logic        irq,
    input  logic        irq_en,
    input  logic [7:0]  InteruptAdrReg,
    output logic        irq_ack,
    output logic        in_isr,
    output logic        halted,
    output logic        wdt_err,
    output logic [15:0] retired
);

    ficState_t   state;
    ficState_t   nextState;
    logic        started;
    logic [7:0]  pc;
    logic [7:0]  pcNext;
    logic [7:0]  epc;
    logic [7:0]  epcNext;
    logic        inIsr;
    logic        inIsrNext;
    logic        loadStage;
    logic        retire;
    logic        wdtClear;
    logic        wdtRun;
    logic        wdtExpire;
    logic        wdtErr;
    logic        irqPending;

    fic_watchdog #(
        .LIMIT (WDT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (wdtClear),
        .run      (wdtRun),
        .complete (StageComplete),
        .expire   (wdtExpire),
        .wdtErr   (wdtErr)
    );

    assign wdtRun     = (state == EXEC);
    assign irqPending = irq && irq_en;

    always_comb begin
        nextState = state;
        pcNext    = pc;
        epcNext   = epc;
        inIsrNext = inIsr;
        loadStage = 1'b0;
        retire    = 1'b0;
        wdtClear  = 1'b0;
        case (state)
            FETCH: begin
                if (started && imem_ack) begin
                    loadStage = 1'b1;
                    wdtClear  = 1'b1;
                    nextState = EXEC;
                end
            end
            EXEC: begin
                if (StageComplete) begin
                    retire = 1'b1;
                    if (StageRegInstr_out == HALT_OPCODE) begin
                        pcNext    = NextPctr;
                        nextState = HALT;
                    end else if ((StageRegInstr_out == RETI_OPCODE) && inIsr) begin
                        pcNext    = epc;
                        inIsrNext = 1'b0;
                        nextState = FETCH;
                    end else if (irqPending && !inIsr) begin
                        epcNext   = NextPctr;
                        nextState = IRQ;
                    end else begin
                        pcNext    = NextPctr;
                        nextState = FETCH;
                    end
                end else if (wdtExpire) begin
                    nextState = HALT;
                end
            end
            IRQ: begin
                pcNext    = InteruptAdrReg;
                inIsrNext = 1'b1;
                nextState = FETCH;
            end
            HALT: begin
                // A watchdog halt is terminal until reset.
                if (irqPending && !wdtErr) begin
                    epcNext   = pc;
                    nextState = IRQ;
                end
            end
            default: begin
                nextState = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    // started keeps imem_req low while reset is asserted even though state is FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            started              <= 1'b0;
            pc                   <= RESET_VECTOR;
            epc                  <= 8'h00;
            inIsr                <= 1'b0;
            StageRegInstr_out    <= 5'h00;
            StageRegAddrMode_out <= 3'h0;
            StageRegData_out     <= 8'h00;
            StageRegPCtr_out     <= 8'h00;
            retired              <= 16'h0000;
        end else begin
            started <= 1'b1;
            pc      <= pcNext;
            epc     <= epcNext;
            inIsr   <= inIsrNext;
            if (loadStage) begin
                StageRegInstr_out    <= opcodeOf(imem_rdata);
                StageRegAddrMode_out <= modeOf(imem_rdata);
                StageRegData_out     <= dataOf(imem_rdata);
                StageRegPCtr_out     <= pc;
            end
            if (retire) begin
                retired <= retired + 16'd1;
            end
        end
    end

    assign imem_req    = (state == FETCH) && started;
    assign imem_addr   = pc;
    assign stage_valid = (state == EXEC);
    assign irq_ack     = (state == IRQ);
    assign halted      = (state == HALT);
    assign in_isr      = inIsr;
    assign wdt_err     = wdtErr;

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Directed bench for fetch_issue_ctrl: table-driven sequential issue plus
// hand-written interrupt, HALT, watchdog and async-reset sequences.
module tb_fetch_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [4:0]  StageRegInstr_out;
    logic [2:0]  StageRegAddrMode_out;
    logic [7:0]  StageRegData_out;
    logic [7:0]  StageRegPCtr_out;
    logic        stage_valid;
    logic        StageComplete;
    logic [7:0]  NextPctr;
    logic        irq;
    logic        irq_en;
    logic [7:0]  InteruptAdrReg;
    logic        irq_ack;
    logic        in_isr;
    logic        halted;
    logic        wdt_err;
    logic [15:0] retired;

    int checks = 0;
    int errors = 0;

    fetch_issue_ctrl #(
        .RESET_VECTOR (8'h00),
        .HALT_OPCODE  (5'h1F),
        .RETI_OPCODE  (5'h1E),
        .WDT_CYCLES   (8)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_ack             (imem_ack),
        .imem_rdata           (imem_rdata),
        .StageRegInstr_out    (StageRegInstr_out),
        .StageRegAddrMode_out (StageRegAddrMode_out),
        .StageRegData_out     (StageRegData_out),
        .StageRegPCtr_out     (StageRegPCtr_out),
        .stage_valid          (stage_valid),
        .StageComplete        (StageComplete),
        .NextPctr             (NextPctr),
        .irq                  (irq),
        .irq_en               (irq_en),
        .InteruptAdrReg       (InteruptAdrReg),
        .irq_ack              (irq_ack),
        .in_isr               (in_isr),
        .halted               (halted),
        .wdt_err              (wdt_err),
        .retired              (retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] rdata;
        logic [7:0]  addr;
        logic [7:0]  nextPc;
        logic [4:0]  opc;
        logic [2:0]  mode;
        logic [7:0]  data;
        logic [15:0] ret;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetchIssue(input logic [7:0] expAddr, input logic [15:0] rdata, input string tag);
        int n = 0;
        while (!imem_req && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(imem_req), 32'd1);
        check({tag, "_addr"}, 32'(imem_addr), 32'(expAddr));
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        check({tag, "_valid"}, 32'(stage_valid), 32'd1);
        check({tag, "_reqDrop"}, 32'(imem_req), 32'd0);
    endtask

    task automatic complete(input logic [7:0] np);
        StageComplete = 1'b1;
        NextPctr      = np;
        tick();
        StageComplete = 1'b0;
        NextPctr      = 8'h00;
    endtask

    initial begin
        int seen;

        vecs[0] = '{16'h0A55, 8'h00, 8'h01, 5'h01, 3'h2, 8'h55, 16'd1};
        vecs[1] = '{16'h1234, 8'h01, 8'h02, 5'h02, 3'h2, 8'h34, 16'd2};
        vecs[2] = '{16'hF0A5, 8'h02, 8'h03, 5'h1E, 3'h0, 8'hA5, 16'd3};
        vecs[3] = '{16'h7FFF, 8'h03, 8'hFF, 5'h0F, 3'h7, 8'hFF, 16'd4};
        vecs[4] = '{16'h0000, 8'hFF, 8'h00, 5'h00, 3'h0, 8'h00, 16'd5};

        reset          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 16'h0000;
        StageComplete  = 1'b0;
        NextPctr       = 8'h00;
        irq            = 1'b0;
        irq_en         = 1'b0;
        InteruptAdrReg = 8'h80;

        #2;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'h00);
        check("rst_valid", 32'(stage_valid), 32'd0);
        check("rst_instr", 32'(StageRegInstr_out), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        tick();
        tick();
        reset = 1'b1;

        // Sequential issue; RETI outside the ISR and PC wrap are ordinary here.
        for (int i = 0; i < 5; i++) begin
            fetchIssue(vecs[i].addr, vecs[i].rdata, $sformatf("seq%0d", i));
            check($sformatf("seq%0d_opc", i), 32'(StageRegInstr_out), 32'(vecs[i].opc));
            check($sformatf("seq%0d_mode", i), 32'(StageRegAddrMode_out), 32'(vecs[i].mode));
            check($sformatf("seq%0d_data", i), 32'(StageRegData_out), 32'(vecs[i].data));
            check($sformatf("seq%0d_pctr", i), 32'(StageRegPCtr_out), 32'(vecs[i].addr));
            complete(vecs[i].nextPc);
            check($sformatf("seq%0d_retired", i), 32'(retired), 32'(vecs[i].ret));
            check($sformatf("seq%0d_inIsr", i), 32'(in_isr), 32'd0);
        end

        // Interrupt entry at a boundary, no nesting, RETI back to epc.
        InteruptAdrReg = 8'h80;
        fetchIssue(8'h00, 16'h0801, "irqA");
        irq    = 1'b1;
        irq_en = 1'b1;
        complete(8'h05);
        check("irq_ack", 32'(irq_ack), 32'd1);
        check("irq_reqLow", 32'(imem_req), 32'd0);
        tick();
        check("irq_ackPulse", 32'(irq_ack), 32'd0);
        check("irq_inIsr", 32'(in_isr), 32'd1);
        fetchIssue(8'h80, 16'h1000, "isr1");
        complete(8'h81);
        check("isr_noNest", 32'(irq_ack), 32'd0);
        irq = 1'b0;
        fetchIssue(8'h81, 16'hF000, "reti");
        complete(8'h82);
        check("reti_inIsr", 32'(in_isr), 32'd0);
        check("reti_retired", 32'(retired), 32'd8);

        // HALT, then interrupt wake-up; RETI returns to the HALT's NextPctr.
        fetchIssue(8'h05, 16'hF800, "halt");
        complete(8'h06);
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_retired", 32'(retired), 32'd9);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (imem_req || !halted) seen++;
        end
        check("halt_hold20", 32'(seen), 32'd0);
        InteruptAdrReg = 8'h40;
        irq = 1'b1;
        tick();
        irq = 1'b0;
        check("haltIrq_ack", 32'(irq_ack), 32'd1);
        check("haltIrq_halted", 32'(halted), 32'd0);
        tick();
        check("haltIrq_inIsr", 32'(in_isr), 32'd1);
        fetchIssue(8'h40, 16'hF000, "reti2");
        complete(8'h41);
        fetchIssue(8'h06, 16'h0807, "noEn");
        irq    = 1'b1;
        irq_en = 1'b0;
        complete(8'h07);
        check("noEn_ack", 32'(irq_ack), 32'd0);
        check("noEn_retired", 32'(retired), 32'd11);
        irq    = 1'b0;
        irq_en = 1'b1;

        // Completion on the 8th EXEC cycle is not a timeout.
        fetchIssue(8'h07, 16'h0809, "wdtEdge");
        for (int i = 0; i < 7; i++) tick();
        check("wdtEdge_valid", 32'(stage_valid), 32'd1);
        complete(8'h08);
        check("wdtEdge_err", 32'(wdt_err), 32'd0);
        check("wdtEdge_retired", 32'(retired), 32'd12);

        // Timeout after 8 EXEC cycles without completion.
        fetchIssue(8'h08, 16'h080A, "wdt");
        for (int i = 0; i < 7; i++) tick();
        check("wdt_notYet", 32'(wdt_err), 32'd0);
        tick();
        check("wdt_err", 32'(wdt_err), 32'd1);
        check("wdt_halted", 32'(halted), 32'd1);
        check("wdt_retired", 32'(retired), 32'd12);
        check("wdt_addr", 32'(imem_addr), 32'h08);
        irq = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (irq_ack || imem_req || !halted) seen++;
        end
        check("wdt_irqIgnored", 32'(seen), 32'd0);
        irq = 1'b0;
        reset = 1'b0;
        #1;
        check("wdt_rstClears", 32'(wdt_err), 32'd0);
        check("wdt_rstHalted", 32'(halted), 32'd0);
        tick();
        reset = 1'b1;

        // Async reset in the middle of an ISR instruction's EXEC.
        InteruptAdrReg = 8'h80;
        fetchIssue(8'h00, 16'h0A55, "post");
        irq = 1'b1;
        complete(8'h01);
        tick();
        irq = 1'b0;
        check("post_inIsr", 32'(in_isr), 32'd1);
        fetchIssue(8'h80, 16'h1234, "isrExec");
        check("isrExec_pctr", 32'(StageRegPCtr_out), 32'h80);
        #3;
        reset = 1'b0;
        #1;
        check("async_valid", 32'(stage_valid), 32'd0);
        check("async_req", 32'(imem_req), 32'd0);
        check("async_inIsr", 32'(in_isr), 32'd0);
        check("async_instr", 32'(StageRegInstr_out), 32'd0);
        check("async_pctr", 32'(StageRegPCtr_out), 32'd0);
        check("async_retired", 32'(retired), 32'd0);
        check("async_addr", 32'(imem_addr), 32'h00);
        tick();
        reset = 1'b1;
        fetchIssue(8'h00, 16'h0A55, "release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

endmodule
